imem_fetch_responder: RTL and testbench
=======================================

IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 Parameter N, default 32, SHALL be the address and instruction word width.
REQ-002 Parameter DEPTH, default 256, SHALL be the number of N-bit instruction words stored.
REQ-003 Parameter NOP_WORD, default 32'h00000013, SHALL be the word returned on any error response.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port req_valid, input, 1 bit: the fetch address is valid.
REQ-007 Port req_ready, output, 1 bit: the block can accept a fetch this cycle.
REQ-008 Port req_pc, input, N bits: the byte address to fetch (the program counter value).
REQ-009 Port rsp_valid, output, 1 bit: a response is presented.
REQ-010 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 Port rsp_instr, output, N bits: the fetched instruction word.
REQ-012 Port rsp_pc, output, N bits: the req_pc that produced this response.
REQ-013 Port rsp_err, output, 1 bit: the fetch was out of range or misaligned.
REQ-014 Port flush, input, 1 bit: discard all in-flight and buffered responses.
REQ-015 Port wr_en, input, 1 bit: program-load write strobe.
REQ-016 Ports wr_addr (input, N bits, byte address) and wr_data (input, N bits): the program-load word.

Function
REQ-017 Accept SHALL occur when req_valid and req_ready are both 1 at a rising edge; the word index is req_pc[N-1:2].
REQ-018 Read latency SHALL be 1: the response for an accept at edge k SHALL enter the response buffer at edge k+1.
REQ-019 The response buffer SHALL be a 2-entry FIFO with occupancy states EMPTY, ONE and FULL, and SHALL present the oldest entry on rsp_valid, rsp_instr, rsp_pc and rsp_err.
REQ-020 A pop SHALL occur when rsp_valid and rsp_ready are both 1; a push and a pop at the same edge SHALL leave the occupancy unchanged and preserve order.
REQ-021 req_ready SHALL be a registered output that is 1 only when (occupancy + in-flight reads) < 2, so the FIFO never overflows.
REQ-022 If the word index is >= DEPTH, the response SHALL carry rsp_err=1 and rsp_instr=NOP_WORD.
REQ-023 A write with wr_en=1 SHALL update the word at wr_addr[N-1:2] at the edge; a write with an index >= DEPTH SHALL be ignored.
REQ-024 A read and a write to the same index at the same edge SHALL return the old data.
REQ-025 flush=1 at an edge SHALL empty the FIFO and cancel the in-flight read, so that rsp_valid=0 after that edge.
REQ-026 A request accepted at the same edge as flush SHALL be discarded.
REQ-027 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs SHALL remain stable.

Reset
REQ-028 Asserting rst SHALL immediately force the FIFO to EMPTY, clear the in-flight flag, and drive rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0 and req_ready=0.
REQ-029 req_ready SHALL rise at the first rising edge after rst deasserts.
REQ-030 Reset asserted mid-transaction SHALL discard all responses and SHALL NOT clear memory contents.

Configuration
REQ-031 With macro IMEM_MISALIGN_CHECK_EN defined, a req_pc with req_pc[1:0] != 0 SHALL produce rsp_err=1 and rsp_instr=NOP_WORD.
REQ-032 With IMEM_MISALIGN_CHECK_EN undefined, req_pc[1:0] SHALL be ignored and misalignment SHALL NOT cause an error.

Verification
REQ-033 Load 0x00500093 at address 0x0, then request pc=0x0 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_instr=0x00500093, rsp_pc=0x0, rsp_err=0.
REQ-034 Hold rsp_ready=0 and issue back-to-back requests at 0x0, 0x4, 0x8 -> req_ready=0 after two accepts; releasing rsp_ready returns 0x0 then 0x4 in order, and the third request is accepted only after that.
REQ-035 Request pc=0x400 with DEPTH=256 -> rsp_err=1, rsp_instr=0x00000013.
REQ-036 Request pc=0x2 -> rsp_err=1 when IMEM_MISALIGN_CHECK_EN is defined; otherwise the word at index 0 is returned with rsp_err=0.
REQ-037 With FULL occupancy, assert flush and req_valid together -> rsp_valid=0 next cycle and no response for the flushed request ever appears.
REQ-038 Assert rst asynchronously mid-cycle while FULL -> rsp_valid=0 immediately; after release, refetching 0x0 returns the preloaded word.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction memory with a 1-cycle fetch path into a 2-entry response FIFO.
// Define IMEM_MISALIGN_CHECK_EN to flag fetches with req_pc[1:0] != 0 as errors.
module imem_fetch_responder #(
    parameter int unsigned    N        = 32,
    parameter int unsigned    DEPTH    = 256,
    parameter logic [N-1:0]   NOP_WORD = N'(32'h00000013)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_pc,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_instr,
    output logic [N-1:0] rsp_pc,
    output logic         rsp_err,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [N-1:0] wr_addr,
    input  logic [N-1:0] wr_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    typedef struct packed {
        logic [N-1:0] instr;
        logic [N-1:0] pc;
        logic         err;
    } entry_t;

    logic [N-1:0] r_mem [DEPTH];

    occ_t         r_state;
    occ_t         w_state_nxt;
    logic         r_inf_valid;
    entry_t       r_inf;
    entry_t       r_ent0;
    entry_t       r_ent1;
    logic         r_req_ready;

    logic [N-3:0] w_rd_idx;
    logic [N-3:0] w_wr_idx;
    logic         w_rd_oob;
    logic         w_rd_mis;
    logic         w_wr_ok;
    entry_t       w_rd_entry;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic         w_inf_nxt;
    logic         w_ld0_inf;
    logic         w_ld0_shift;
    logic         w_ld1_inf;
    logic [1:0]   w_occ_nxt;
    logic         w_ready_nxt;
    logic         w_unused;

    assign w_rd_idx = req_pc[N-1:2];
    assign w_wr_idx = wr_addr[N-1:2];
    assign w_rd_oob = ({2'b00, w_rd_idx} >= N'(DEPTH));
    assign w_wr_ok  = ({2'b00, w_wr_idx} <  N'(DEPTH));
    assign w_unused = &{1'b0, wr_addr[1:0]};

`ifdef IMEM_MISALIGN_CHECK_EN
    assign w_rd_mis = |req_pc[1:0];
`else
    assign w_rd_mis = 1'b0;
`endif

    always_comb begin
        w_rd_entry.pc    = req_pc;
        w_rd_entry.err   = w_rd_oob | w_rd_mis;
        w_rd_entry.instr = w_rd_entry.err ? NOP_WORD : r_mem[w_rd_idx[AW-1:0]];
    end

    assign w_accept  = req_valid & r_req_ready;
    assign w_push    = r_inf_valid;
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_inf_nxt = w_accept & ~flush;

    // Memory is outside the reset domain so program contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[w_wr_idx[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld0_inf   = 1'b0;
        w_ld0_shift = 1'b0;
        w_ld1_inf   = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_ld0_inf   = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_ld0_inf = 1'b1;
                end else if (w_push) begin
                    w_ld1_inf   = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_ld0_shift = 1'b1;
                    if (w_push) begin
                        w_ld1_inf = 1'b1;
                    end else begin
                        w_state_nxt = ONE;
                    end
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
        end
        case (w_state_nxt)
            ONE:     w_occ_nxt = 2'd1;
            FULL:    w_occ_nxt = 2'd2;
            default: w_occ_nxt = 2'd0;
        endcase
        // Ready looks ahead at next occupancy plus the read that will be in flight.
        w_ready_nxt = (w_occ_nxt + {1'b0, w_inf_nxt}) < 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inf_valid <= 1'b0;
            r_inf       <= '0;
            r_ent0      <= '0;
            r_ent1      <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_inf_valid <= w_inf_nxt;
            r_req_ready <= w_ready_nxt;
            if (w_accept) begin
                r_inf <= w_rd_entry;
            end
            if (w_ld0_inf) begin
                r_ent0 <= r_inf;
            end else if (w_ld0_shift) begin
                r_ent0 <= r_ent1;
            end
            if (w_ld1_inf) begin
                r_ent1 <= r_inf;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = (r_state != EMPTY);
    assign rsp_instr = r_ent0.instr;
    assign rsp_pc    = r_ent0.pc;
    assign rsp_err   = r_ent0.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: load, fetch, backpressure, errors, flush, reset.
module tb_imem_fetch_responder;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_pc;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_instr;
    logic [N-1:0] rsp_pc;
    logic         rsp_err;
    logic         flush;
    logic         wr_en;
    logic [N-1:0] wr_addr;
    logic [N-1:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    imem_fetch_responder #(
        .N     (32),
        .DEPTH (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [N-1:0] addr, input logic [N-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
        flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        #2;
        check("rst_rsp_valid", N'(rsp_valid), 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'd0);
        check("rst_rsp_pc",    rsp_pc, 32'd0);
        check("rst_rsp_err",   N'(rsp_err), 32'd0);
        check("rst_req_ready", N'(req_ready), 32'd0);

        tick(); tick();
        rst = 1'b0;
        #1;
        check("ready_before_edge", N'(req_ready), 32'd0);
        tick();
        check("ready_after_release", N'(req_ready), 32'd1);

        load(32'h0000_0000, 32'h0050_0093);
        load(32'h0000_0004, 32'h1111_1111);
        load(32'h0000_0008, 32'h2222_2222);
        load(32'h0000_03FC, 32'hDEAD_BEEF);
        load(32'h0000_0400, 32'hBAD0_BAD0);

        // Basic fetch of word 0, latency 1
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_valid = 1'b0;
        check("basic_latency_valid", N'(rsp_valid), 32'd0);
        check("basic_ready_held", N'(req_ready), 32'd1);
        tick();
        check("basic_valid", N'(rsp_valid), 32'd1);
        check("basic_instr", rsp_instr, 32'h0050_0093);
        check("basic_pc",    rsp_pc, 32'h0);
        check("basic_err",   N'(rsp_err), 32'd0);
        tick();
        check("basic_popped", N'(rsp_valid), 32'd0);

        // Out-of-range fetch
        req_valid = 1'b1; req_pc = 32'h400;
        tick();
        req_valid = 1'b0;
        tick();
        check("oob_valid", N'(rsp_valid), 32'd1);
        check("oob_err",   N'(rsp_err), 32'd1);
        check("oob_instr", rsp_instr, 32'h0000_0013);
        check("oob_pc",    rsp_pc, 32'h400);
        tick();

        // Last in-range word
        req_valid = 1'b1; req_pc = 32'h3FC;
        tick();
        req_valid = 1'b0;
        tick();
        check("last_instr", rsp_instr, 32'hDEAD_BEEF);
        check("last_err",   N'(rsp_err), 32'd0);
        tick();

        // Misaligned fetch
        req_valid = 1'b1; req_pc = 32'h2;
        tick();
        req_valid = 1'b0;
        tick();
        check("mis_valid", N'(rsp_valid), 32'd1);
        check("mis_pc", rsp_pc, 32'h2);
`ifdef IMEM_MISALIGN_CHECK_EN
        check("mis_err",   N'(rsp_err), 32'd1);
        check("mis_instr", rsp_instr, 32'h0000_0013);
`else
        check("mis_err",   N'(rsp_err), 32'd0);
        check("mis_instr", rsp_instr, 32'h0050_0093);
`endif
        tick();

        // Backpressure: three back-to-back requests with consumer stalled
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        check("bp_ready_after1", N'(req_ready), 32'd1);
        req_pc = 32'h4;
        tick();
        check("bp_ready_after2", N'(req_ready), 32'd0);
        req_pc = 32'h8;
        tick();
        check("bp_ready_full", N'(req_ready), 32'd0);
        check("bp_head_valid", N'(rsp_valid), 32'd1);
        check("bp_head_pc",    rsp_pc, 32'h0);
        tick();
        check("bp_stable_instr", rsp_instr, 32'h0050_0093);
        check("bp_stable_pc",    rsp_pc, 32'h0);
        rsp_ready = 1'b1;
        tick();
        check("bp_second_pc",    rsp_pc, 32'h4);
        check("bp_second_instr", rsp_instr, 32'h1111_1111);
        check("bp_ready_again",  N'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_empty_gap", N'(rsp_valid), 32'd0);
        tick();
        check("bp_third_valid", N'(rsp_valid), 32'd1);
        check("bp_third_pc",    rsp_pc, 32'h8);
        check("bp_third_instr", rsp_instr, 32'h2222_2222);
        tick();
        check("bp_drained", N'(rsp_valid), 32'd0);

        // Read and write of the same word at one edge returns old data
        req_valid = 1'b1; req_pc = 32'h4;
        wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h3333_3333;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        tick();
        check("rw_old", rsp_instr, 32'h1111_1111);
        tick();
        req_valid = 1'b1; req_pc = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        check("rw_new", rsp_instr, 32'h3333_3333);
        tick();

        // Flush while FULL with a request presented
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_pc = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        check("fl_full_valid", N'(rsp_valid), 32'd1);
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'h8;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("fl_valid_cleared", N'(rsp_valid), 32'd0);
        check("fl_ready", N'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_ghost", N'(rsp_valid), 32'd0);
        end

        // Request accepted on the flush edge is discarded
        req_valid = 1'b1; req_pc = 32'h0; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        tick();
        check("fl_accept_dropped", N'(rsp_valid), 32'd0);
        tick();
        check("fl_accept_dropped2", N'(rsp_valid), 32'd0);

        // Asynchronous reset while FULL
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_pc = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        check("ar_full_valid", N'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid",  N'(rsp_valid), 32'd0);
        check("ar_ready",  N'(req_ready), 32'd0);
        check("ar_instr",  rsp_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_ready_back", N'(req_ready), 32'd1);
        check("ar_still_empty", N'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        check("ar_mem_kept_valid", N'(rsp_valid), 32'd1);
        check("ar_mem_kept", rsp_instr, 32'h0050_0093);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
